// File: rtl/serial_adder.sv
// Bit-serial WIDTH-bit adder: one full-adder slice (two half adders + OR) per clock, LSB first,
// with a start/done handshake and registered sum/carry results.
module serial_adder #(
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    output logic [WIDTH-1:0] sum,
    output logic             carry,
    output logic             busy,
    output logic             done
);

    localparam int CW = $clog2(WIDTH);

    localparam logic [1:0] IDLE = 2'b00;
    localparam logic [1:0] ADD  = 2'b01;
    localparam logic [1:0] DONE = 2'b10;

    localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

    // Half adder cell: returns {carry, sum}.
    function automatic logic [1:0] half_add(input logic x, input logic y);
        half_add = {x & y, x ^ y};
    endfunction

    logic [1:0]       state_r;
    logic [WIDTH-1:0] shift_a_r;
    logic [WIDTH-1:0] shift_b_r;
    logic [WIDTH-1:0] psum_r;
    logic             cbit_r;
    logic [CW-1:0]    count_r;
    logic [WIDTH-1:0] sum_r;
    logic             carry_r;
    logic             busy_r;
    logic             done_r;

    logic [1:0]       ha1_s;
    logic [1:0]       ha2_s;
    logic             s_s;
    logic             c_s;

    // Full-adder slice on the current LSBs and the carry from the previous bit.
    always_comb begin
        ha1_s = half_add(shift_a_r[0], shift_b_r[0]);
        ha2_s = half_add(ha1_s[0], cbit_r);
        s_s   = ha2_s[0];
        c_s   = ha1_s[1] | ha2_s[1];
    end

    // Control FSM and bit-serial datapath.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_r   <= IDLE;
            shift_a_r <= {WIDTH{1'b0}};
            shift_b_r <= {WIDTH{1'b0}};
            psum_r    <= {WIDTH{1'b0}};
            cbit_r    <= 1'b0;
            count_r   <= {CW{1'b0}};
            sum_r     <= {WIDTH{1'b0}};
            carry_r   <= 1'b0;
            busy_r    <= 1'b0;
            done_r    <= 1'b0;
        end else begin
            case (state_r)
                IDLE: begin
                    done_r <= 1'b0;
                    if (start) begin
                        shift_a_r <= a;
                        shift_b_r <= b;
                        cbit_r    <= 1'b0;
                        count_r   <= {CW{1'b0}};
                        busy_r    <= 1'b1;
                        state_r   <= ADD;
                    end else begin
                        busy_r    <= 1'b0;
                    end
                end
                ADD: begin
                    busy_r    <= 1'b1;
                    psum_r    <= {s_s, psum_r[WIDTH-1:1]};
                    shift_a_r <= {1'b0, shift_a_r[WIDTH-1:1]};
                    shift_b_r <= {1'b0, shift_b_r[WIDTH-1:1]};
                    cbit_r    <= c_s;
                    count_r   <= count_r + {{(CW-1){1'b0}}, 1'b1};
                    // The last slice's sum bit goes straight into the result, not via psum_r.
                    if (count_r == LAST) begin
                        sum_r   <= {s_s, psum_r[WIDTH-1:1]};
                        carry_r <= c_s;
                        done_r  <= 1'b1;
                        state_r <= DONE;
                    end else begin
                        done_r  <= 1'b0;
                    end
                end
                DONE: begin
                    done_r  <= 1'b0;
                    busy_r  <= 1'b0;
                    state_r <= IDLE;
                end
                default: begin
                    done_r  <= 1'b0;
                    busy_r  <= 1'b0;
                    state_r <= IDLE;
                end
            endcase
        end
    end

    assign sum   = sum_r;
    assign carry = carry_r;
    assign busy  = busy_r;
    assign done  = done_r;

endmodule
